// File: rtl/spi_bus_arbiter.sv
// Two-port arbiter in front of a single SPI master: grants one requester per
// transaction, returns completion/read data to it, and guards the bus with a watchdog.
module spi_bus_arbiter #(
    parameter int          DATA_W      = 24,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096,
    parameter bit          RR_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [1:0]        req0_cmd,
    input  logic [7:0]        req0_width,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic [1:0]        req1_cmd,
    input  logic [7:0]        req1_width,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              spi_start,
    output logic [1:0]        spi_cmd,
    output logic [7:0]        spi_width,
    output logic [DATA_W-1:0] spi_wdata,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_rdata,
    output logic              busy,
    output logic              timeout_sticky
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        spi_cmd_q, spi_cmd_d;
    logic [7:0]        spi_width_q, spi_width_d;
    logic [DATA_W-1:0] spi_wdata_q, spi_wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              sticky_q, sticky_d;
    logic              ready0_q, ready0_d;
    logic              ready1_q, ready1_d;
    logic              start_q, start_d;
    logic              win;
    logic [7:0]        win_width;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        spi_cmd_d    = spi_cmd_q;
        spi_width_d  = spi_width_q;
        spi_wdata_d  = spi_wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        sticky_d     = sticky_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        start_d      = 1'b0;
        win          = 1'b0;
        win_width    = 8'd0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie, round-robin hands the bus to whoever did not have it last.
                    if (req0_valid && req1_valid) win = RR_EN ? ~last_grant_q : 1'b0;
                    else                          win = req1_valid;
                    win_width    = win ? req1_width : req0_width;
                    grant_d      = win;
                    last_grant_d = win;
                    spi_cmd_d    = win ? req1_cmd   : req0_cmd;
                    spi_width_d  = win_width;
                    spi_wdata_d  = win ? req1_wdata : req0_wdata;
                    ready0_d     = ~win;
                    ready1_d     = win;
                    cnt_d        = 16'd0;
                    if (win_width == 8'd0) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        start_d = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (spi_done) begin
                    rsp_rdata_d = spi_rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (TIMEOUT_CYC != 16'd0 && cnt_q == TIMEOUT_CYC - 16'd1) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    sticky_d    = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                cnt_d   = 16'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 16'd0;
            spi_cmd_q    <= 2'd0;
            spi_width_q  <= 8'd0;
            spi_wdata_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            sticky_q     <= 1'b0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            spi_cmd_q    <= spi_cmd_d;
            spi_width_q  <= spi_width_d;
            spi_wdata_q  <= spi_wdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            sticky_q     <= sticky_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            start_q      <= start_d;
        end
    end

    assign req0_ready     = ready0_q;
    assign req1_ready     = ready1_q;
    assign req0_done      = (state_q == RESP) && !grant_q;
    assign req1_done      = (state_q == RESP) && grant_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign spi_start      = start_q;
    assign spi_cmd        = spi_cmd_q;
    assign spi_width      = spi_width_q;
    assign spi_wdata      = spi_wdata_q;
    assign busy           = (state_q != IDLE);
    assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench: a round-robin/long-watchdog instance and a fixed-priority/8-cycle
// watchdog instance share one stimulus stream.
module tb_spi_bus_arbiter;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req1_valid, spi_done;
    logic [1:0] req0_cmd, req1_cmd;
    logic [7:0] req0_width, req1_width;
    logic [DW-1:0] req0_wdata, req1_wdata, spi_rdata;

    logic a_req0_ready, a_req0_done, a_req1_ready, a_req1_done, a_rsp_err, a_spi_start, a_busy, a_sticky;
    logic [1:0] a_spi_cmd;
    logic [7:0] a_spi_width;
    logic [DW-1:0] a_rsp_rdata, a_spi_wdata;
    logic b_req0_ready, b_req0_done, b_req1_ready, b_req1_done, b_rsp_err, b_spi_start, b_busy, b_sticky;
    logic [1:0] b_spi_cmd;
    logic [7:0] b_spi_width;
    logic [DW-1:0] b_rsp_rdata, b_spi_wdata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(16'd4096), .RR_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_width(req0_width), .req0_wdata(req0_wdata),
        .req0_ready(a_req0_ready), .req0_done(a_req0_done),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_width(req1_width), .req1_wdata(req1_wdata),
        .req1_ready(a_req1_ready), .req1_done(a_req1_done),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .spi_start(a_spi_start), .spi_cmd(a_spi_cmd), .spi_width(a_spi_width), .spi_wdata(a_spi_wdata),
        .spi_done(spi_done), .spi_rdata(spi_rdata),
        .busy(a_busy), .timeout_sticky(a_sticky)
    );

    spi_bus_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(16'd8), .RR_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_width(req0_width), .req0_wdata(req0_wdata),
        .req0_ready(b_req0_ready), .req0_done(b_req0_done),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_width(req1_width), .req1_wdata(req1_wdata),
        .req1_ready(b_req1_ready), .req1_done(b_req1_done),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .spi_start(b_spi_start), .spi_cmd(b_spi_cmd), .spi_width(b_spi_width), .spi_wdata(b_spi_wdata),
        .spi_done(spi_done), .spi_rdata(spi_rdata),
        .busy(b_busy), .timeout_sticky(b_sticky)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc, iss0, don0, don1, polls, viol, mcnt;
        logic [DW-1:0] mdata;

        rst_n = 1'b0; spi_done = 1'b0; spi_rdata = '0;
        req0_valid = 1'b0; req0_cmd = 2'd0; req0_width = 8'd0; req0_wdata = '0;
        req1_valid = 1'b0; req1_cmd = 2'd0; req1_width = 8'd0; req1_wdata = '0;
        step(); step();
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_start", a_spi_start, 1'b0);
        chk1("rst_ready0", a_req0_ready, 1'b0);
        chk1("rst_done0", a_req0_done, 1'b0);
        chk1("rst_err", a_rsp_err, 1'b0);
        chk1("rst_sticky", b_sticky, 1'b0);
        chkw("rst_wdata", a_spi_wdata, 24'h0);
        rst_n = 1'b1;
        step();

        // Single request, master answers about 30 cycles after the start pulse
        req0_valid = 1'b1; req0_cmd = 2'd0; req0_width = 8'd24; req0_wdata = 24'h000114;
        step();
        chk1("single_ready0", a_req0_ready, 1'b1);
        chk1("single_start", a_spi_start, 1'b1);
        chkw("single_wdata", a_spi_wdata, 24'h000114);
        chk1("single_busy", a_busy, 1'b1);
        req0_valid = 1'b0;
        step();
        chk1("single_ready_pulse", a_req0_ready, 1'b0);
        chk1("single_start_pulse", a_spi_start, 1'b0);
        repeat (28) step();
        chk1("single_no_early_done", a_req0_done, 1'b0);
        spi_done = 1'b1; spi_rdata = 24'hABCDEF;
        step();
        spi_done = 1'b0;
        chk1("single_done0", a_req0_done, 1'b1);
        chk1("single_done1", a_req1_done, 1'b0);
        chkw("single_rdata", a_rsp_rdata, 24'hABCDEF);
        chk1("single_err", a_rsp_err, 1'b0);
        step();
        chk1("single_done_pulse", a_req0_done, 1'b0);
        chk1("single_idle", a_busy, 1'b0);
        chkw("single_wdata_hold", a_spi_wdata, 24'h000114);

        // Contention: both ports valid for four transactions
        do_reset();
        req0_valid = 1'b1; req0_cmd = 2'd1; req0_width = 8'd8;  req0_wdata = 24'h111111;
        req1_valid = 1'b1; req1_cmd = 2'd2; req1_width = 8'd16; req1_wdata = 24'h222222;
        for (int t = 0; t < 4; t++) begin
            step();
            chk1("rr_ready0", a_req0_ready, (t % 2) == 0);
            chk1("rr_ready1", a_req1_ready, (t % 2) == 1);
            chkw("rr_wdata", a_spi_wdata, (t % 2) == 1 ? 24'h222222 : 24'h111111);
            chk1("fp_ready0", b_req0_ready, 1'b1);
            chk1("fp_ready1", b_req1_ready, 1'b0);
            spi_done = 1'b1; spi_rdata = 24'hC00000 + 24'(t);
            step();
            spi_done = 1'b0;
            chk1("rr_done1", a_req1_done, (t % 2) == 1);
            chkw("rr_rdata", a_rsp_rdata, 24'hC00000 + 24'(t));
            chk1("fp_done0", b_req0_done, 1'b1);
            step();
        end
        req0_valid = 1'b0;
        step();
        chk1("fp_port1_served", b_req1_ready, 1'b1);
        chk1("fp_port1_cmd", b_spi_cmd == 2'd2, 1'b1);
        req1_valid = 1'b0;
        spi_done = 1'b1; spi_rdata = 24'h000333;
        step();
        spi_done = 1'b0;
        chk1("fp_port1_done", b_req1_done, 1'b1);
        step();

        // Watchdog expiry on the 8-cycle instance, then a stray spi_done while idle
        do_reset();
        req0_valid = 1'b1; req0_width = 8'd24; req0_wdata = 24'h000042;
        step();
        chk1("to_ready0", b_req0_ready, 1'b1);
        req0_valid = 1'b0;
        repeat (7) step();
        chk1("to_not_yet", b_req0_done, 1'b0);
        chk1("to_still_busy", b_busy, 1'b1);
        step();
        chk1("to_done0", b_req0_done, 1'b1);
        chk1("to_err", b_rsp_err, 1'b1);
        chkw("to_rdata", b_rsp_rdata, 24'h0);
        chk1("to_sticky", b_sticky, 1'b1);
        chk1("to_long_wd_waits", a_busy, 1'b1);
        step();
        chk1("to_idle", b_busy, 1'b0);
        spi_done = 1'b1; spi_rdata = 24'h777777;
        step();
        spi_done = 1'b0;
        chk1("stray_busy", b_busy, 1'b0);
        chk1("stray_done0", b_req0_done, 1'b0);
        chk1("stray_done1", b_req1_done, 1'b0);
        chkw("stray_rdata", b_rsp_rdata, 24'h0);
        chk1("stray_err", b_rsp_err, 1'b1);
        step();
        req1_valid = 1'b1; req1_width = 8'd16; req1_wdata = 24'h000099;
        step();
        chk1("after_to_ready1", b_req1_ready, 1'b1);
        chk1("after_to_start", b_spi_start, 1'b1);
        req1_valid = 1'b0;
        step(); step();
        spi_done = 1'b1; spi_rdata = 24'h5A5A5A;
        step();
        spi_done = 1'b0;
        chk1("after_to_done1", b_req1_done, 1'b1);
        chk1("after_to_err", b_rsp_err, 1'b0);
        chkw("after_to_rdata", b_rsp_rdata, 24'h5A5A5A);
        chk1("after_to_sticky", b_sticky, 1'b1);
        step();

        // spi_done on the last watchdog cycle wins over expiry
        do_reset();
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        repeat (7) step();
        spi_done = 1'b1; spi_rdata = 24'h123456;
        step();
        spi_done = 1'b0;
        chk1("edge_done0", b_req0_done, 1'b1);
        chk1("edge_err", b_rsp_err, 1'b0);
        chkw("edge_rdata", b_rsp_rdata, 24'h123456);
        chk1("edge_sticky", b_sticky, 1'b0);
        step();

        // Zero-width request on port 1
        req1_valid = 1'b1; req1_width = 8'd0; req1_wdata = 24'h0000AA;
        step();
        req1_valid = 1'b0;
        chk1("zw_ready1", a_req1_ready, 1'b1);
        chk1("zw_no_start", a_spi_start, 1'b0);
        chk1("zw_done1", a_req1_done, 1'b1);
        chk1("zw_err", a_rsp_err, 1'b1);
        chkw("zw_rdata", a_rsp_rdata, 24'h0);
        step();
        chk1("zw_idle", a_busy, 1'b0);
        chk1("zw_done_pulse", a_req1_done, 1'b0);

        // Reset in the middle of WAIT
        req0_valid = 1'b1; req0_width = 8'd24; req0_wdata = 24'h0000BB;
        step();
        req0_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk1("mid_busy", a_busy, 1'b0);
        chk1("mid_done0", a_req0_done, 1'b0);
        chkw("mid_wdata", a_spi_wdata, 24'h0);
        chk1("mid_err", a_rsp_err, 1'b0);
        spi_done = 1'b1; spi_rdata = 24'h444444;
        step();
        spi_done = 1'b0;
        chk1("mid_late_done0", a_req0_done, 1'b0);
        chk1("mid_late_busy", a_busy, 1'b0);
        chkw("mid_late_rdata", a_rsp_rdata, 24'h0);
        req0_valid = 1'b1; req1_valid = 1'b1; req1_width = 8'd16;
        step();
        chk1("mid_tie_ready0", a_req0_ready, 1'b1);
        chk1("mid_tie_ready1", a_req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        step();

        // Soak: port 0 streams 153 writes, port 1 polls every 50 cycles
        do_reset();
        cyc = 0; iss0 = 0; don0 = 0; don1 = 0; polls = 0; viol = 0; mcnt = 0; mdata = '0;
        req0_valid = 1'b1; req0_cmd = 2'd0; req0_width = 8'd24; req0_wdata = 24'h010000;
        req1_valid = 1'b0; req1_cmd = 2'd2; req1_width = 8'd16; req1_wdata = 24'hF00000;
        while (!(don0 == 153 && !req1_valid && don1 == polls) && cyc < 20000) begin
            step();
            cyc++;
            if (a_req0_ready) begin
                iss0++;
                if (iss0 < 153) req0_wdata = 24'h010000 + 24'(iss0);
                else            req0_valid = 1'b0;
            end
            if (a_req1_ready) req1_valid = 1'b0;
            if (a_req0_done) begin
                chkw("soak_wr_rdata", a_rsp_rdata, 24'h010001 + 24'(don0));
                don0++;
            end
            if (a_req1_done) begin
                chkw("soak_poll_rdata", a_rsp_rdata, 24'hF00001);
                don1++;
            end
            spi_done = 1'b0;
            if (a_spi_start) begin
                if (mcnt != 0) viol++;
                mcnt  = 3;
                mdata = a_spi_wdata + 24'd1;
            end else if (mcnt != 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    spi_done  = 1'b1;
                    spi_rdata = mdata;
                end
            end
            if (cyc % 50 == 0 && iss0 < 153 && !req1_valid) begin
                req1_valid = 1'b1;
                polls++;
            end
        end
        chk1("soak_in_budget", cyc < 20000, 1'b1);
        chkw("soak_writes", 24'(don0), 24'd153);
        chkw("soak_polls", 24'(don1), 24'(polls));
        chk1("soak_polls_seen", polls > 5, 1'b1);
        chkw("soak_overlap", 24'(viol), 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
